trigger_sequencer: RTL and testbench

- Upstream driver for enable_control, single clock domain clkA.
- Issues a programmable number of trigger trials on trg and runs a four-phase handshake against the done flag returned from the clkB domain.
- Synchronizes done internally and counts completed trials.
- Flags a timeout if the downstream stage stops responding.

---
 rtl/trigger_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_trigger_sequencer.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/trigger_sequencer.sv
// Trigger sequencer: issues a programmed number of trigger trials on trg and
// runs a four-phase handshake against a done flag arriving from another clock domain.
module trigger_sequencer #(
    parameter int CNT_W = 8,
    parameter int GAP_W = 4,
    parameter int TO_W  = 6
) (
    input  logic             clkA,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [CNT_W-1:0] n_trials,
    input  logic [GAP_W-1:0] gap,
    input  logic             done_async,
    output logic             trg,
    output logic             busy,
    output logic [CNT_W-1:0] trial_cnt,
    output logic             finished,
    output logic             timeout_err
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARM     = 3'd1,
        ST_RELEASE = 3'd2,
        ST_GAP     = 3'd3,
        ST_FINISH  = 3'd4,
        ST_ERROR   = 3'd5
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [GAP_W-1:0] GAP_ZERO = {GAP_W{1'b0}};
    localparam logic [GAP_W-1:0] GAP_ONE  = {{(GAP_W-1){1'b0}}, 1'b1};
    localparam logic [TO_W-1:0]  TO_ZERO  = {TO_W{1'b0}};
    localparam logic [TO_W-1:0]  TO_ONE   = {{(TO_W-1){1'b0}}, 1'b1};
    // The counter reaches its all-ones value on the edge that leaves the phase,
    // so the decision is taken one count earlier.
    localparam logic [TO_W-1:0]  TO_LAST  = {TO_W{1'b1}} - TO_ONE;

    state_t           state_r;
    state_t           state_nx_s;
    logic [1:0]       sync_r;
    logic             done_s;
    logic [CNT_W-1:0] n_r;
    logic [GAP_W-1:0] gap_r;
    logic [CNT_W-1:0] trial_cnt_r;
    logic [CNT_W-1:0] cnt_plus1_s;
    logic [GAP_W-1:0] gap_cnt_r;
    logic [TO_W-1:0]  to_cnt_r;
    logic             trg_r;
    logic             busy_r;
    logic             finished_r;
    logic             timeout_err_r;
    logic             accept_s;
    logic             trial_done_s;

    assign done_s      = sync_r[1];
    assign cnt_plus1_s = trial_cnt_r + CNT_ONE;

    // Two-flop synchronizer for the done flag from the clkB domain.
    always_ff @(posedge clkA) begin
        if (rst) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], done_async};
        end
    end

    // Next-state decode; abort outranks acknowledge and timeout.
    always_comb begin
        state_nx_s   = state_r;
        accept_s     = 1'b0;
        trial_done_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    accept_s   = 1'b1;
                    state_nx_s = (n_trials == CNT_ZERO) ? ST_FINISH : ST_ARM;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ARM: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else if (done_s) begin
                    state_nx_s = ST_RELEASE;
                end else if (to_cnt_r == TO_LAST) begin
                    state_nx_s = ST_ERROR;
                end else begin
                    state_nx_s = ST_ARM;
                end
            end
            ST_RELEASE: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else if (!done_s) begin
                    trial_done_s = 1'b1;
                    if (cnt_plus1_s == n_r) begin
                        state_nx_s = ST_FINISH;
                    end else if (gap_r == GAP_ZERO) begin
                        state_nx_s = ST_ARM;
                    end else begin
                        state_nx_s = ST_GAP;
                    end
                end else if (to_cnt_r == TO_LAST) begin
                    state_nx_s = ST_ERROR;
                end else begin
                    state_nx_s = ST_RELEASE;
                end
            end
            ST_GAP: begin
                if (abort) begin
                    state_nx_s = ST_IDLE;
                end else if (gap_cnt_r == gap_r) begin
                    state_nx_s = ST_ARM;
                end else begin
                    state_nx_s = ST_GAP;
                end
            end
            ST_FINISH: begin
                state_nx_s = ST_IDLE;
            end
            ST_ERROR: begin
                state_nx_s = ST_IDLE;
            end
            default: begin
                state_nx_s = ST_IDLE;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clkA) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Run parameters, trial counter, gap and timeout counters.
    always_ff @(posedge clkA) begin
        if (rst) begin
            n_r         <= CNT_ZERO;
            gap_r       <= GAP_ZERO;
            trial_cnt_r <= CNT_ZERO;
            gap_cnt_r   <= GAP_ZERO;
            to_cnt_r    <= TO_ZERO;
        end else begin
            if (accept_s) begin
                n_r         <= n_trials;
                gap_r       <= gap;
                trial_cnt_r <= CNT_ZERO;
            end else if (trial_done_s) begin
                trial_cnt_r <= cnt_plus1_s;
            end else begin
                trial_cnt_r <= trial_cnt_r;
            end

            if (state_r == ST_GAP && state_nx_s == ST_GAP) begin
                gap_cnt_r <= gap_cnt_r + GAP_ONE;
            end else begin
                gap_cnt_r <= GAP_ZERO;
            end

            // Any state change clears the timeout count, covering every entry to ARM or RELEASE.
            if (state_nx_s != state_r) begin
                to_cnt_r <= TO_ZERO;
            end else if (state_r == ST_ARM || state_r == ST_RELEASE) begin
                to_cnt_r <= to_cnt_r + TO_ONE;
            end else begin
                to_cnt_r <= TO_ZERO;
            end
        end
    end

    // Outputs registered from the next state so they align with the state register.
    always_ff @(posedge clkA) begin
        if (rst) begin
            trg_r         <= 1'b0;
            busy_r        <= 1'b0;
            finished_r    <= 1'b0;
            timeout_err_r <= 1'b0;
        end else begin
            trg_r      <= (state_nx_s == ST_ARM);
            busy_r     <= (state_nx_s != ST_IDLE);
            finished_r <= (state_nx_s == ST_FINISH);
            if (accept_s) begin
                timeout_err_r <= 1'b0;
            end else if (state_nx_s == ST_ERROR) begin
                timeout_err_r <= 1'b1;
            end else begin
                timeout_err_r <= timeout_err_r;
            end
        end
    end

    assign trg         = trg_r;
    assign busy        = busy_r;
    assign trial_cnt   = trial_cnt_r;
    assign finished    = finished_r;
    assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_trigger_sequencer.sv
// Directed bench for trigger_sequencer: handshake timing, gap, timeout, abort and reset.
module tb_trigger_sequencer;

    logic       clkA = 1'b0;
    logic       rst;
    logic       start;
    logic       abort;
    logic [7:0] n_trials;
    logic [3:0] gap;
    logic       done_async;
    logic       trg;
    logic       busy;
    logic [7:0] trial_cnt;
    logic       finished;
    logic       timeout_err;

    int tests = 0;
    int fails = 0;

    trigger_sequencer #(.CNT_W(8), .GAP_W(4), .TO_W(6)) dut (
        .clkA        (clkA),
        .rst         (rst),
        .start       (start),
        .abort       (abort),
        .n_trials    (n_trials),
        .gap         (gap),
        .done_async  (done_async),
        .trg         (trg),
        .busy        (busy),
        .trial_cnt   (trial_cnt),
        .finished    (finished),
        .timeout_err (timeout_err)
    );

    always #5 clkA = ~clkA;

    task automatic step();
        @(posedge clkA);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic start_run(input logic [7:0] n, input logic [3:0] g);
        start    = 1'b1;
        n_trials = n;
        gap      = g;
        step();
        start    = 1'b0;
    endtask

    // One handshake from an ARM state already entered: done rises after 'pre'
    // cycles, is seen 3 edges later, then falls and is seen 3 edges later.
    task automatic trial(input int pre, input int gp, input bit last, input logic [7:0] cb);
        repeat (pre) step();
        chk("arm_hold", trg, 32'd1);
        done_async = 1'b1;
        step();
        step();
        chk("trg_wait_sync", trg, 32'd1);
        step();
        chk("trg_fall", trg, 32'd0);
        chk("cnt_in_release", trial_cnt, {24'd0, cb});
        done_async = 1'b0;
        step();
        step();
        chk("cnt_wait_release", trial_cnt, {24'd0, cb});
        step();
        chk("cnt_incr", trial_cnt, {24'd0, cb} + 32'd1);
        if (last) begin
            chk("finished_pulse", finished, 32'd1);
            chk("busy_at_finish", busy, 32'd1);
            chk("trg_at_finish", trg, 32'd0);
            step();
            chk("finished_end", finished, 32'd0);
            chk("busy_drop", busy, 32'd0);
            chk("cnt_hold", trial_cnt, {24'd0, cb} + 32'd1);
        end else if (gp == 0) begin
            chk("trg_rerise_nogap", trg, 32'd1);
        end else begin
            repeat (gp) step();
            chk("trg_gap_low", trg, 32'd0);
            chk("busy_in_gap", busy, 32'd1);
            step();
            chk("trg_after_gap", trg, 32'd1);
        end
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        n_trials   = 8'd0;
        gap        = 4'd0;
        done_async = 1'b0;
        step();
        step();
        rst = 1'b0;
        chk("rst_trg", trg, 32'd0);
        chk("rst_busy", busy, 32'd0);
        chk("rst_cnt", trial_cnt, 32'd0);
        chk("rst_fin", finished, 32'd0);
        chk("rst_to", timeout_err, 32'd0);

        // Three trials with a two-cycle gap.
        start_run(8'd3, 4'd2);
        chk("run1_trg", trg, 32'd1);
        chk("run1_busy", busy, 32'd1);
        trial(5, 2, 1'b0, 8'd0);
        trial(5, 2, 1'b0, 8'd1);
        trial(5, 2, 1'b1, 8'd2);

        // Zero trials, with abort in the same cycle as start.
        abort = 1'b1;
        start_run(8'd0, 4'd0);
        abort = 1'b0;
        chk("zero_fin", finished, 32'd1);
        chk("zero_busy", busy, 32'd1);
        chk("zero_trg", trg, 32'd0);
        chk("zero_cnt", trial_cnt, 32'd0);
        step();
        chk("zero_fin_end", finished, 32'd0);
        chk("zero_busy_end", busy, 32'd0);

        // Gap of zero, and a start pulse while busy must not change the run.
        start_run(8'd2, 4'd0);
        start    = 1'b1;
        n_trials = 8'd5;
        step();
        start = 1'b0;
        chk("ignore_start_trg", trg, 32'd1);
        trial(4, 0, 1'b0, 8'd0);
        trial(5, 0, 1'b1, 8'd1);

        // Abort in RELEASE after one completed trial.
        start_run(8'd3, 4'd1);
        trial(5, 1, 1'b0, 8'd0);
        repeat (5) step();
        done_async = 1'b1;
        step();
        step();
        step();
        chk("abort_pre_trg", trg, 32'd0);
        abort = 1'b1;
        start = 1'b1;
        step();
        abort = 1'b0;
        start = 1'b0;
        chk("abort_busy", busy, 32'd0);
        chk("abort_trg", trg, 32'd0);
        chk("abort_cnt", trial_cnt, 32'd1);
        chk("abort_fin", finished, 32'd0);
        done_async = 1'b0;
        step();
        chk("abort_idle_busy", busy, 32'd0);
        chk("abort_idle_fin", finished, 32'd0);
        step();
        step();

        // Timeout: done never rises, trg stays high for 63 cycles.
        start_run(8'd2, 4'd3);
        repeat (62) step();
        chk("to_trg_last", trg, 32'd1);
        chk("to_flag_early", timeout_err, 32'd0);
        step();
        chk("to_trg_drop", trg, 32'd0);
        chk("to_flag", timeout_err, 32'd1);
        chk("to_busy_err", busy, 32'd1);
        chk("to_fin_err", finished, 32'd0);
        step();
        chk("to_busy_idle", busy, 32'd0);
        chk("to_sticky", timeout_err, 32'd1);
        chk("to_cnt", trial_cnt, 32'd0);
        chk("to_fin_idle", finished, 32'd0);
        step();
        chk("to_sticky_idle", timeout_err, 32'd1);
        start_run(8'd1, 4'd0);
        chk("to_clear", timeout_err, 32'd0);
        trial(5, 0, 1'b1, 8'd0);

        // Reset while in ARM after one completed trial.
        start_run(8'd3, 4'd0);
        trial(5, 0, 1'b0, 8'd0);
        step();
        step();
        chk("prerst_trg", trg, 32'd1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("midrst_trg", trg, 32'd0);
        chk("midrst_busy", busy, 32'd0);
        chk("midrst_cnt", trial_cnt, 32'd0);
        chk("midrst_fin", finished, 32'd0);
        chk("midrst_to", timeout_err, 32'd0);
        step();
        chk("midrst_stay_idle", busy, 32'd0);
        start_run(8'd1, 4'd0);
        chk("postrst_trg", trg, 32'd1);
        trial(5, 0, 1'b1, 8'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
